uart_rx_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver and extracts framed packets.

---
 rtl/uart_rx_frame_parser.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_parser
//
// Extracts framed packets from the UART receiver byte stream and releases
// the payload of each good frame on a valid/ready/last byte stream.
//
// Frame on the wire:  SOF, LEN, LEN payload bytes, CSUM
//   CSUM = LEN ^ payload[0] ^ ... ^ payload[LEN-1]
//
// The whole payload is buffered before anything is emitted, so a frame with
// a bad checksum never reaches the downstream command logic.
//
// Ports
//   clk_i        in   clock
//   arst_i       in   asynchronous reset, active-high
//   in_data_i    in   [7:0] byte from the UART receiver
//   in_valid_i   in   byte strobe (one-cycle pulse per byte)
//   in_ready_o   out  parser can take a byte (low only while emitting)
//   out_data_o   out  [7:0] payload byte
//   out_valid_o  out  out_data_o is valid
//   out_last_o   out  marks the last payload byte of the frame
//   out_ready_i  in   downstream accepts the current byte
//   frame_ok_o   out  one-cycle pulse: frame passed the checksum
//   frame_err_o  out  one-cycle pulse: error event
//   err_code_o   out  [1:0] 0=LEN_BAD 1=CSUM_BAD 2=TIMEOUT 3=OVERRUN (holds)
// ---------------------------------------------------------------------------
module uart_rx_frame_parser #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 150_000
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    output logic       out_last_o,
    input  logic       out_ready_i,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    // The error fires on the edge where the timer would step onto
    // TIMEOUT_CYC-1, i.e. TIMEOUT_CYC-1 cycles after the last accepted byte.
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 2);

    localparam logic [1:0] ERR_LEN_BAD  = 2'd0;
    localparam logic [1:0] ERR_CSUM_BAD = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_EMIT
    } state_t;

    state_t           state, state_d;
    logic [7:0]       len, len_d;
    logic [7:0]       csum, csum_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [IDX_W-1:0] rd, rd_d;
    logic [IDX_W-1:0] rd_nxt;
    logic [TMR_W-1:0] timer, timer_d;

    logic             in_ready_d;
    logic [7:0]       out_data_d;
    logic             out_valid_d;
    logic             out_last_d;
    logic             frame_ok_d;
    logic             frame_err_d;
    logic [1:0]       err_code_d;

    logic             accept;
    logic             out_hs;
    logic             tmr_run;
    logic             tmo;
    logic             wr_en;
    logic             pay_last;

    logic [7:0]       pay_mem [MAX_LEN];

    assign accept   = in_valid_i && in_ready_o;
    assign out_hs   = out_valid_o && out_ready_i;
    assign tmr_run  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    assign tmo      = tmr_run && !accept && (timer == TMO_LAST);
    assign pay_last = (8'(idx) == (len - 8'd1));
    assign rd_nxt   = rd + IDX_W'(1);

    // Payload buffer: data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            pay_mem[idx] <= in_data_i;
        end
    end

    // ---- Next-state and registered-output logic ----
    always_comb begin
        state_d     = state;
        len_d       = len;
        csum_d      = csum;
        idx_d       = idx;
        rd_d        = rd;
        timer_d     = '0;
        out_data_d  = out_data_o;
        out_valid_d = out_valid_o;
        out_last_d  = out_last_o;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_o;
        wr_en       = 1'b0;

        // Saturating inter-byte timer; an accept always wins over a timeout.
        if (tmr_run && !accept && (timer != '1)) begin
            timer_d = timer + TMR_W'(1);
        end

        case (state)
            ST_HUNT: begin
                if (accept && (in_data_i == SOF_BYTE)) begin
                    state_d = ST_LEN;
                    csum_d  = 8'h00;
                end
            end

            ST_LEN: begin
                if (accept) begin
                    if ((in_data_i == 8'h00) || (in_data_i > 8'(MAX_LEN))) begin
                        state_d     = ST_HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN_BAD;
                    end else begin
                        state_d = ST_PAYLOAD;
                        len_d   = in_data_i;
                        csum_d  = in_data_i;
                        idx_d   = '0;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    csum_d = csum ^ in_data_i;
                    idx_d  = idx + IDX_W'(1);
                    if (pay_last) begin
                        state_d = ST_CSUM;
                    end
                end
            end

            ST_CSUM: begin
                if (accept) begin
                    if (in_data_i == csum) begin
                        state_d     = ST_EMIT;
                        frame_ok_d  = 1'b1;
                        rd_d        = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = pay_mem[0];
                        out_last_d  = (len == 8'd1);
                    end else begin
                        state_d     = ST_HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM_BAD;
                    end
                end
            end

            ST_EMIT: begin
                if (out_hs) begin
                    if (out_last_o) begin
                        state_d     = ST_HUNT;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        rd_d       = rd_nxt;
                        out_data_d = pay_mem[rd_nxt];
                        out_last_d = (8'(rd_nxt) == (len - 8'd1));
                    end
                end
                // in_ready_o is low here, so any strobe is a dropped byte.
                if (in_valid_i) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (tmo) begin
            state_d     = ST_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        in_ready_d = (state_d != ST_EMIT);
    end

    // ---- State and output registers ----
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= ST_HUNT;
            len         <= 8'h00;
            csum        <= 8'h00;
            idx         <= '0;
            rd          <= '0;
            timer       <= '0;
            in_ready_o  <= 1'b1;
            out_data_o  <= 8'h00;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= 2'd0;
        end else begin
            state       <= state_d;
            len         <= len_d;
            csum        <= csum_d;
            idx         <= idx_d;
            rd          <= rd_d;
            timer       <= timer_d;
            in_ready_o  <= in_ready_d;
            out_data_o  <= out_data_d;
            out_valid_o <= out_valid_d;
            out_last_o  <= out_last_d;
            frame_ok_o  <= frame_ok_d;
            frame_err_o <= frame_err_d;
            err_code_o  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_parser
//
// Directed bench for uart_rx_frame_parser. Bytes are driven one per two
// clocks; a negedge monitor records emitted bytes and ok/err pulses, and the
// main sequence compares them against hand-computed frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_parser;

    localparam int TMO = 64;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_last_o;
    logic       out_ready_i;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;

    uart_rx_frame_parser #(
        .MAX_LEN    (16),
        .SOF_BYTE   (8'hA5),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_last_o (out_last_o),
        .out_ready_i(out_ready_i),
        .frame_ok_o (frame_ok_o),
        .frame_err_o(frame_err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [7:0] byte_q_t[$];

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state (written only by the monitor process)
    logic [8:0] cap_mem [0:255];
    int         cap_wr   = 0;
    int         ok_cnt   = 0;
    int         err_cnt  = 0;
    int         vld_cnt  = 0;
    logic [1:0] last_code = 2'd0;

    int cap_rd = 0;

    always @(negedge clk_i) begin
        if (out_valid_o) vld_cnt <= vld_cnt + 1;
        if (out_valid_o && out_ready_i && cap_wr < 256) begin
            cap_mem[cap_wr] <= {out_last_o, out_data_o};
            cap_wr          <= cap_wr + 1;
        end
        if (frame_ok_o) ok_cnt <= ok_cnt + 1;
        if (frame_err_o) begin
            err_cnt   <= err_cnt + 1;
            last_code <= err_code_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i); #1;
        in_data_i  = b;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Compare captured payload bytes since the last call against exp.
    task automatic chk_out(input string tag, input byte_q_t exp);
        chk({tag, "_count"}, cap_wr - cap_rd, exp.size());
        foreach (exp[i]) begin
            if (cap_rd + i < cap_wr) begin
                chk($sformatf("%s_data%0d", tag, i), cap_mem[cap_rd + i][7:0], exp[i]);
                chk($sformatf("%s_last%0d", tag, i), cap_mem[cap_rd + i][8],
                    (i == exp.size() - 1) ? 1 : 0);
            end
        end
        cap_rd = cap_wr;
    endtask

    int ok_b, err_b, vld_b, n;
    byte_q_t big;

    initial begin
        arst_i      = 1'b1;
        in_data_i   = 8'h00;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #23;
        chk("rst_in_ready",  in_ready_o,  1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data",  out_data_o,  0);
        chk("rst_out_last",  out_last_o,  0);
        chk("rst_ok",        frame_ok_o,  0);
        chk("rst_err",       frame_err_o, 0);
        chk("rst_code",      err_code_o,  0);
        arst_i = 1'b0;
        idle(2);

        // 1: good 3-byte frame, csum 03^11^22^33 = 03
        ok_b = ok_cnt; err_b = err_cnt;
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
        send_byte(8'h03);
        chk("t1_lat_valid", out_valid_o, 1);
        chk("t1_lat_ok",    frame_ok_o,  1);
        chk("t1_lat_data",  out_data_o,  8'h11);
        chk("t1_in_ready",  in_ready_o,  0);
        idle(8);
        chk_out("t1", '{8'h11, 8'h22, 8'h33});
        chk("t1_ok_cnt",  ok_cnt - ok_b, 1);
        chk("t1_err_cnt", err_cnt - err_b, 0);
        chk("t1_in_ready_after", in_ready_o, 1);

        // 2: leading garbage ignored, 1-byte frame
        ok_b = ok_cnt; err_b = err_cnt;
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
        idle(5);
        chk_out("t2", '{8'h7E});
        chk("t2_ok_cnt",  ok_cnt - ok_b, 1);
        chk("t2_err_cnt", err_cnt - err_b, 0);

        // 3: bad checksum (correct would be 02^10^20 = 32)
        ok_b = ok_cnt; err_b = err_cnt; vld_b = vld_cnt;
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h20});
        send_byte(8'h00);
        chk("t3_err_pulse", frame_err_o, 1);
        chk("t3_code",      err_code_o,  1);
        idle(5);
        chk("t3_err_cnt", err_cnt - err_b, 1);
        chk("t3_ok_cnt",  ok_cnt - ok_b, 0);
        chk("t3_no_valid", vld_cnt - vld_b, 0);
        chk_out("t3", '{});

        // 4: LEN 0 and LEN 17 rejected, then a good frame
        ok_b = ok_cnt; err_b = err_cnt;
        send_seq('{8'hA5, 8'h00});
        chk("t4a_code", err_code_o, 0);
        chk("t4a_pulse", frame_err_o, 1);
        send_seq('{8'hA5, 8'h11});
        chk("t4b_code", err_code_o, 0);
        idle(2);
        chk("t4_err_cnt", err_cnt - err_b, 2);
        chk("t4_last_code", last_code, 0);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        idle(8);
        chk_out("t4", '{8'h11, 8'h22, 8'h33});
        chk("t4_ok_cnt", ok_cnt - ok_b, 1);

        // 4b: LEN == MAX_LEN accepted; payload 00..0F XORs to 0, csum = 10
        ok_b = ok_cnt;
        big = {};
        for (int i = 0; i < 16; i++) big.push_back(8'(i));
        send_seq('{8'hA5, 8'h10});
        send_seq(big);
        send_byte(8'h10);
        idle(22);
        chk_out("t4max", big);
        chk("t4max_ok_cnt", ok_cnt - ok_b, 1);

        // 5: timeout TMO-1 cycles after the last accepted byte
        ok_b = ok_cnt; err_b = err_cnt;
        send_seq('{8'hA5, 8'h02, 8'h10});
        n = 0;
        for (int k = 1; k <= 3 * TMO; k++) begin
            @(posedge clk_i); #1;
            if (frame_err_o) begin
                n = k;
                break;
            end
        end
        chk("t5_tmo_cycles", n, TMO - 1);
        chk("t5_code", err_code_o, 2);
        send_seq('{8'hA5, 8'h01, 8'h7E, 8'h7F});
        idle(5);
        chk_out("t5", '{8'h7E});
        chk("t5_err_cnt", err_cnt - err_b, 1);
        chk("t5_ok_cnt",  ok_cnt - ok_b, 1);

        // 6: stalled emission with an overrun byte injected
        ok_b = ok_cnt; err_b = err_cnt;
        out_ready_i = 1'b0;
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        idle(5);
        @(posedge clk_i); #1;
        in_data_i  = 8'h55;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        chk("t6_err_pulse", frame_err_o, 1);
        chk("t6_code",      err_code_o,  3);
        idle(13);
        chk("t6_hold_valid", out_valid_o, 1);
        chk("t6_hold_data",  out_data_o,  8'h11);
        chk("t6_hold_last",  out_last_o,  0);
        chk("t6_in_ready",   in_ready_o,  0);
        out_ready_i = 1'b1;
        idle(8);
        chk_out("t6", '{8'h11, 8'h22, 8'h33});
        chk("t6_err_cnt", err_cnt - err_b, 1);
        chk("t6_ok_cnt",  ok_cnt - ok_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
